nrs_ls_estimator: RTL

NRS_LS_ESTIMATOR -- requirements
Module: nrs_ls_estimator

---
 rtl/nrs_ls_estimator.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/nrs_ls_estimator.sv
// NRS least-squares channel estimator: derotates each received NRS RE by the
// conjugate of its unit-amplitude reference symbol and averages the subframe.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begins one subframe (honoured in IDLE only)
//   rx_valid/rx_ready        received sample handshake, rx_re/rx_im samples
//   rd_addr_est, nrs_est     NRS value read port (1-cycle synchronous read)
//   h_valid, h_re/h_im/h_idx per-RE estimate
//   mean_valid, mean_re/im   subframe mean estimate
//   busy                     high whenever the FSM is not IDLE
module nrs_ls_estimator #(
    parameter int RE_W          = 16,
    parameter int NRS_WIDTH_R_I = 16,
    parameter int LINES         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     rx_valid,
    input  logic signed [RE_W-1:0]   rx_re,
    input  logic signed [RE_W-1:0]   rx_im,
    output logic                     rx_ready,
    output logic [LINES-1:0]         rd_addr_est,
    input  logic [NRS_WIDTH_R_I-1:0] nrs_est,
    output logic                     h_valid,
    output logic signed [RE_W:0]     h_re,
    output logic signed [RE_W:0]     h_im,
    output logic [LINES-1:0]         h_idx,
    output logic                     mean_valid,
    output logic signed [RE_W:0]     mean_re,
    output logic signed [RE_W:0]     mean_im,
    output logic                     busy
);

    localparam int HW = RE_W + 1;
    localparam int AW = RE_W + LINES + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LINES-1:0]       r_cnt;
    logic                   r_v1;
    logic signed [RE_W-1:0] r_d1_re;
    logic signed [RE_W-1:0] r_d1_im;
    logic [LINES-1:0]       r_d1_idx;
    logic                   r_v2;
    logic signed [RE_W-1:0] r_d2_re;
    logic signed [RE_W-1:0] r_d2_im;
    logic [LINES-1:0]       r_d2_idx;
    logic                   r_sr;
    logic                   r_si;
    logic signed [AW-1:0]   r_acc_re;
    logic signed [AW-1:0]   r_acc_im;
    logic                   r_h_valid;
    logic signed [HW-1:0]   r_h_re;
    logic signed [HW-1:0]   r_h_im;
    logic [LINES-1:0]       r_h_idx;
    logic                   r_mean_valid;
    logic signed [HW-1:0]   r_mean_re;
    logic signed [HW-1:0]   r_mean_im;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_finish;
    logic signed [HW-1:0]   w_re_x;
    logic signed [HW-1:0]   w_im_x;
    logic signed [HW-1:0]   w_sr_re;
    logic signed [HW-1:0]   w_si_im;
    logic signed [HW-1:0]   w_sr_im;
    logic signed [HW-1:0]   w_si_re;
    logic signed [HW-1:0]   w_h_re;
    logic signed [HW-1:0]   w_h_im;

    assign w_accept = rx_valid && (r_state == S_RUN);
    assign w_last   = w_accept && (r_cnt == {LINES{1'b1}});
    // Pipeline empty while draining: the final h has already been summed.
    assign w_finish = (r_state == S_DRAIN) && !r_v1 && !r_v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_finish) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Unit-amplitude NRS: multiplying by conj(nrs) reduces to sign flips.
    assign w_re_x  = {r_d2_re[RE_W-1], r_d2_re};
    assign w_im_x  = {r_d2_im[RE_W-1], r_d2_im};
    assign w_sr_re = r_sr ? -w_re_x : w_re_x;
    assign w_si_im = r_si ? -w_im_x : w_im_x;
    assign w_sr_im = r_sr ? -w_im_x : w_im_x;
    assign w_si_re = r_si ? -w_re_x : w_re_x;
    assign w_h_re  = w_sr_re + w_si_im;
    assign w_h_im  = w_sr_im - w_si_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_v1         <= 1'b0;
            r_d1_re      <= '0;
            r_d1_im      <= '0;
            r_d1_idx     <= '0;
            r_v2         <= 1'b0;
            r_d2_re      <= '0;
            r_d2_im      <= '0;
            r_d2_idx     <= '0;
            r_sr         <= 1'b0;
            r_si         <= 1'b0;
            r_acc_re     <= '0;
            r_acc_im     <= '0;
            r_h_valid    <= 1'b0;
            r_h_re       <= '0;
            r_h_im       <= '0;
            r_h_idx      <= '0;
            r_mean_valid <= 1'b0;
            r_mean_re    <= '0;
            r_mean_im    <= '0;
        end else begin
            // Stage 1: capture the sample; its address stays on the read
            // port until this edge, so the NRS word arrives one cycle later.
            r_v1 <= w_accept;
            if (w_accept) begin
                r_d1_re  <= rx_re;
                r_d1_im  <= rx_im;
                r_d1_idx <= r_cnt;
                r_cnt    <= r_cnt + 1'b1;
            end

            // Stage 2: pair the sample with its NRS sign bits.
            r_v2 <= r_v1;
            if (r_v1) begin
                r_d2_re  <= r_d1_re;
                r_d2_im  <= r_d1_im;
                r_d2_idx <= r_d1_idx;
                r_sr     <= nrs_est[NRS_WIDTH_R_I-1];
                r_si     <= nrs_est[NRS_WIDTH_R_I/2-1];
            end

            // Stage 3: publish h and fold it into the running sums.
            r_h_valid <= r_v2;
            if (r_v2) begin
                r_h_re   <= w_h_re;
                r_h_im   <= w_h_im;
                r_h_idx  <= r_d2_idx;
                r_acc_re <= r_acc_re + {{(AW-HW){w_h_re[HW-1]}}, w_h_re};
                r_acc_im <= r_acc_im + {{(AW-HW){w_h_im[HW-1]}}, w_h_im};
            end

            if ((r_state == S_IDLE) && start) begin
                r_cnt    <= '0;
                r_acc_re <= '0;
                r_acc_im <= '0;
            end

            // Mean is registered on entry to DONE so its pulse spans DONE.
            r_mean_valid <= w_finish;
            if (w_finish) begin
                r_mean_re <= HW'(r_acc_re >>> LINES);
                r_mean_im <= HW'(r_acc_im >>> LINES);
            end
        end
    end

    assign rx_ready    = (r_state == S_RUN);
    assign rd_addr_est = r_cnt;
    assign busy        = (r_state != S_IDLE);
    assign h_valid     = r_h_valid;
    assign h_re        = r_h_re;
    assign h_im        = r_h_im;
    assign h_idx       = r_h_idx;
    assign mean_valid  = r_mean_valid;
    assign mean_re     = r_mean_re;
    assign mean_im     = r_mean_im;

endmodule
